// File: rtl/ddp_pkt_pkg.sv
// Shared definitions for the DDP test-packet path.
//   TABLE_DEPTH / PKT_WIDTH : packet table geometry
//   *_MSB / *_LSB           : packet field positions (header, gen, dest, flags, data)
//   HDR_VALID               : header code marking a table entry as a real packet
//   send_state_t            : packet_send_ctrl sequencer states
package ddp_pkt_pkg;

  localparam int unsigned TABLE_DEPTH = 20;
  localparam int unsigned PKT_WIDTH   = 38;

  localparam int unsigned HDR_MSB   = 37;
  localparam int unsigned HDR_LSB   = 35;
  localparam int unsigned GEN_MSB   = 34;
  localparam int unsigned GEN_LSB   = 27;
  localparam int unsigned DEST_MSB  = 26;
  localparam int unsigned DEST_LSB  = 20;
  localparam int unsigned FLAGS_MSB = 19;
  localparam int unsigned FLAGS_LSB = 16;
  localparam int unsigned DATA_MSB  = 15;
  localparam int unsigned DATA_LSB  = 0;

  localparam logic [2:0] HDR_VALID = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ_HI,
    ST_REQ_LO,
    ST_GAP,
    ST_FIN
  } send_state_t;

  function automatic logic hdr_is_valid(input logic [PKT_WIDTH-1:0] pkt);
    return pkt[HDR_MSB:HDR_LSB] == HDR_VALID;
  endfunction

endpackage

// File: rtl/packet_send_ctrl_ack_sync.sv
// ack_sync: STAGES-deep flip-flop synchronizer for an asynchronous level.
//   CLK   : destination clock
//   RST_N : asynchronous active-low reset, clears the whole chain
//   D     : asynchronous input
//   Q     : synchronized output (D delayed by STAGES flops)
module ack_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chain <= '0;
    end else begin
      chain[0] <= D;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign Q = chain[STAGES-1];

endmodule

// File: rtl/packet_send_ctrl.sv
// packet_send_ctrl: walks the packet table and injects each valid entry into
// the DDP input stage with a four-phase SEND_REQ/SEND_ACK handshake.
//   CLK, RST_N : clock, asynchronous active-low reset
//   START      : pulse, begins a run when idle
//   STOP       : pulse, abort at the next point where no handshake is open
//   PKT_NUM    : packets requested, sampled on accepted START
//   RD_ADDR    : table read address;  RD_DATA : combinational table data
//   PACKET_OUT : registered packet;   PC_OUT : its table index
//   SEND_REQ   : four-phase request;  SEND_ACK : asynchronous acknowledge
//   SENT_CNT   : completed handshakes this run
//   BUSY       : run in progress;     DONE : one-cycle end-of-run pulse
module packet_send_ctrl
  import ddp_pkt_pkg::*;
#(
  parameter int unsigned DEPTH       = TABLE_DEPTH,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned PKT_W       = PKT_WIDTH,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STOP,
  input  logic [ADDR_W-1:0] PKT_NUM,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [PKT_W-1:0]  RD_DATA,
  output logic [PKT_W-1:0]  PACKET_OUT,
  output logic              SEND_REQ,
  input  logic              SEND_ACK,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [ADDR_W:0]   SENT_CNT,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam int unsigned       GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

  send_state_t       state, state_d;
  logic              ack_s;
  logic              stop_pend;
  logic              stop_eff;
  logic [ADDR_W-1:0] limit_q;
  logic [ADDR_W-1:0] start_limit;
  logic [ADDR_W:0]   sent_inc;
  logic [GAP_W-1:0]  gap_cnt;

  ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (SEND_ACK),
    .Q     (ack_s)
  );

  assign start_limit = (PKT_NUM > DEPTH_A) ? DEPTH_A : PKT_NUM;
  assign sent_inc    = SENT_CNT + 1'b1;
  // A STOP arriving in the same cycle as a decision point takes effect there,
  // not one cycle later.
  assign stop_eff    = stop_pend | STOP;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    SEND_REQ = 1'b0;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          state_d = (start_limit == '0) ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop_eff || !hdr_is_valid(RD_DATA)) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_REQ_HI;
        end
      end
      ST_REQ_HI: begin
        SEND_REQ = 1'b1;
        if (ack_s) begin
          state_d = ST_REQ_LO;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          if (sent_inc == {1'b0, limit_q} || stop_eff) begin
            state_d = ST_FIN;
          end else if (GAP_CYC == 0) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_eff) begin
          state_d = ST_FIN;
        end else if (gap_cnt == GAP_LAST) begin
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RD_ADDR    <= '0;
      PACKET_OUT <= '0;
      PC_OUT     <= '0;
      SENT_CNT   <= '0;
      limit_q    <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            RD_ADDR  <= '0;
            SENT_CNT <= '0;
            limit_q  <= start_limit;
          end
        end
        ST_LOAD: begin
          PACKET_OUT <= RD_DATA;
          PC_OUT     <= RD_ADDR;
        end
        ST_REQ_LO: begin
          if (!ack_s) begin
            SENT_CNT <= sent_inc;
            gap_cnt  <= '0;
            // Advance only when another packet follows, so the address
            // stays within the table at the end of a full run.
            if (state_d == ST_GAP || state_d == ST_LOAD) begin
              RD_ADDR <= RD_ADDR + 1'b1;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
        end
      endcase

      if (state == ST_IDLE || state == ST_FIN) begin
        stop_pend <= 1'b0;
      end else if (STOP) begin
        stop_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_send_ctrl.sv
module tb_packet_send_ctrl;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned SYNC  = 2;

  typedef struct {
    logic [37:0] pkt;
    logic [4:0]  idx;
  } hs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [4:0]  pkt_num;
  logic [4:0]  rd_addr, pc_out;
  logic [37:0] rd_data, pkt_out;
  logic        send_req, send_ack;
  logic [5:0]  sent_cnt;
  logic        busy, done;

  logic        start0, stop0;
  logic [4:0]  pkt_num0, rd_addr0, pc_out0;
  logic [37:0] rd_data0, pkt_out0;
  logic        send_req0, send_ack0;
  logic [5:0]  sent_cnt0;
  logic        busy0, done0;

  logic [37:0] tbl [DEPTH];

  int checks = 0;
  int errors = 0;

  hs_t         exp_hs[$];
  int unsigned exp_done[$];
  hs_t         exp_hs0[$];
  int unsigned exp_done0[$];

  int unsigned ack_dly = 0;
  int unsigned ack_cnt = 0;
  int unsigned max_addr = 0;

  always #5 clk = ~clk;

  assign rd_data  = (rd_addr  < 5'(DEPTH)) ? tbl[rd_addr]  : '0;
  assign rd_data0 = (rd_addr0 < 5'(DEPTH)) ? tbl[rd_addr0] : '0;
  // Zero-delay responder for the GAP_CYC=0 instance.
  assign send_ack0 = send_req0;

  packet_send_ctrl u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .STOP(stop), .PKT_NUM(pkt_num),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data), .PACKET_OUT(pkt_out),
    .SEND_REQ(send_req), .SEND_ACK(send_ack), .PC_OUT(pc_out),
    .SENT_CNT(sent_cnt), .BUSY(busy), .DONE(done)
  );

  packet_send_ctrl #(.GAP_CYC(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start0), .STOP(stop0), .PKT_NUM(pkt_num0),
    .RD_ADDR(rd_addr0), .RD_DATA(rd_data0), .PACKET_OUT(pkt_out0),
    .SEND_REQ(send_req0), .SEND_ACK(send_ack0), .PC_OUT(pc_out0),
    .SENT_CNT(sent_cnt0), .BUSY(busy0), .DONE(done0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Delayed four-phase responder for the main instance.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      send_ack = 1'b0;
      ack_cnt  = 0;
    end else if (send_req != send_ack) begin
      if (ack_cnt >= ack_dly) begin
        send_ack = send_req;
        ack_cnt  = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Monitor / scoreboard, main instance.
  logic        prev_req = 1'b0;
  logic [37:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (send_req && !prev_req) begin
        if (exp_hs.size() == 0) begin
          chk("hs_unexpected_pc", {59'd0, pc_out}, 64'hFFFF);
        end else begin
          hs_t h;
          h = exp_hs.pop_front();
          chk("hs_pkt", {26'd0, pkt_out}, {26'd0, h.pkt});
          chk("hs_pc", {59'd0, pc_out}, {59'd0, h.idx});
        end
        held = pkt_out;
      end else if (send_req) begin
        chk("pkt_stable", {26'd0, pkt_out}, {26'd0, held});
      end
      if (!send_req && prev_req) chk("req_fall_after_ack", {63'd0, send_ack}, 64'd1);
      if (busy && rd_addr > max_addr) max_addr = rd_addr;
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", {58'd0, sent_cnt}, 64'hFFFF);
        else chk("done_sent_cnt", {58'd0, sent_cnt}, 64'(exp_done.pop_front()));
      end
      prev_req = send_req;
    end
  end

  // Monitor / scoreboard, GAP_CYC=0 instance.
  logic        prev_req0 = 1'b0;
  logic [37:0] held0;
  int unsigned low0 = 0;
  int unsigned hs0_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req0 = 1'b0;
    end else begin
      if (send_req0 && !prev_req0) begin
        if (hs0_n > 0) chk("gap0_req_low_cycles", 64'(low0), 64'(SYNC + 2));
        if (exp_hs0.size() == 0) begin
          chk("hs0_unexpected_pc", {59'd0, pc_out0}, 64'hFFFF);
        end else begin
          hs_t h;
          h = exp_hs0.pop_front();
          chk("hs0_pkt", {26'd0, pkt_out0}, {26'd0, h.pkt});
          chk("hs0_pc", {59'd0, pc_out0}, {59'd0, h.idx});
        end
        held0 = pkt_out0;
        hs0_n++;
        low0 = 0;
      end else if (send_req0) begin
        chk("pkt0_stable", {26'd0, pkt_out0}, {26'd0, held0});
      end else if (busy0) begin
        low0++;
      end
      if (done0) begin
        if (exp_done0.size() == 0) chk("done0_unexpected", {58'd0, sent_cnt0}, 64'hFFFF);
        else chk("done0_sent_cnt", {58'd0, sent_cnt0}, 64'(exp_done0.pop_front()));
      end
      prev_req0 = send_req0;
    end
  end

  function automatic logic [37:0] mk_pkt(input logic [2:0] hdr, input logic [15:0] data);
    return {hdr, 8'($urandom), 7'($urandom), 4'($urandom), data};
  endfunction

  task automatic fill_valid();
    for (int unsigned i = 0; i < DEPTH; i++) tbl[i] = mk_pkt(3'b111, 16'(i));
  endtask

  // One run on the main instance: the model walks the table by the rules
  // (limit, header validity, stop point) and queues the expected traffic.
  task automatic run(input int unsigned n, input int unsigned dly, input int stop_at);
    int unsigned lim, cnt, cyc, exp_max;
    bit          seen_req, stopped, hdr_end;
    lim = (n > DEPTH) ? DEPTH : n;
    cnt = 0;
    hdr_end = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      if (tbl[i][37:35] != 3'b111) begin
        hdr_end = 1'b1;
        break;
      end
      exp_hs.push_back('{pkt: tbl[i], idx: 5'(i)});
      cnt++;
      if (stop_at == int'(i)) break;
    end
    exp_done.push_back(cnt);
    exp_max = (lim == 0) ? 0 : (hdr_end ? cnt : cnt - 1);

    ack_dly  = dly;
    max_addr = 0;
    @(negedge clk);
    start   = 1'b1;
    pkt_num = 5'(n);
    @(negedge clk);
    start   = 1'b0;
    pkt_num = 5'($urandom);
    cyc = 1;
    seen_req = 1'b0;
    stopped  = 1'b0;
    while (!done && cyc < 3000) begin
      if (send_req && !seen_req) begin
        seen_req = 1'b1;
        chk("start_to_req_cycles", 64'(cyc), 64'd2);
      end
      if (stop_at >= 0 && !stopped && send_req && int'(pc_out) == stop_at) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end else begin
        stop = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    stop = 1'b0;
    if (!done) begin
      chk("run_timeout_done", 64'd0, 64'd1);
    end else if (n == 0) begin
      chk("zero_run_done_cycles", 64'(cyc), 64'd1);
    end
    @(negedge clk);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("done_single_pulse", {63'd0, done}, 64'd0);
    chk("rd_addr_max", 64'(max_addr), 64'(exp_max));
    chk("hs_queue_drained", 64'(exp_hs.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    exp_hs.delete();
    exp_done.delete();
  endtask

  initial begin
    int unsigned cyc;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pkt_num = '0;
    start0 = 1'b0; stop0 = 1'b0; pkt_num0 = '0;
    fill_valid();
    repeat (3) @(negedge clk);
    chk("rst_req", {63'd0, send_req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_outputs", {26'd0, pkt_out} | {58'd0, sent_cnt} | {59'd0, rd_addr} | {59'd0, pc_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic four-packet run, data field = index.
    run(4, 3, -1);
    // Entry 5 invalid: stops after five packets, no request for entry 5.
    tbl[5] = '0;
    run(8, 2, -1);
    fill_valid();
    // STOP during packet 2 with a slow acknowledge.
    run(8, 10, 2);
    // Zero and over-range packet counts.
    run(0, 1, -1);
    run(25, 1, -1);

    // Asynchronous reset while packet 2 is being requested.
    ack_dly = 10;
    for (int unsigned i = 0; i < 3; i++) exp_hs.push_back('{pkt: tbl[i], idx: 5'(i)});
    @(negedge clk);
    start = 1'b1; pkt_num = 5'd10;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(send_req && pc_out == 5'd2) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_pkt2_req", {63'd0, send_req}, 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {63'd0, send_req}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_sent_cnt", {58'd0, sent_cnt}, 64'd0);
    chk("async_rst_addr", {59'd0, rd_addr} | {59'd0, pc_out}, 64'd0);
    chk("async_rst_pkt", {26'd0, pkt_out}, 64'd0);
    exp_hs.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(3, 1, -1);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] = mk_pkt(($urandom_range(0, 15) < 14) ? 3'b111 : 3'($urandom_range(0, 6)),
                        16'($urandom));
      end
      run($urandom_range(0, 25), $urandom_range(0, 4),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1);
    end

    // GAP_CYC=0 instance: back-to-back packets, immediate acknowledge.
    fill_valid();
    for (int unsigned i = 0; i < 6; i++) exp_hs0.push_back('{pkt: tbl[i], idx: 5'(i)});
    exp_done0.push_back(6);
    @(negedge clk);
    start0 = 1'b1; pkt_num0 = 5'd6;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("gap0_done_seen", {63'd0, done0}, 64'd1);
    @(negedge clk);
    chk("gap0_hs_count", 64'(hs0_n), 64'd6);
    chk("gap0_queue_drained", 64'(exp_hs0.size() + exp_done0.size()), 64'd0);
    chk("gap0_busy_after", {63'd0, busy0}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_send_ctrl.md
Name: packet_send_ctrl

Overview:
Sequences injection of test packets from the 20-entry packet table into the DDP input port. Walks the table address, registers each 38-bit packet, and drives a four-phase SEND_REQ/SEND_ACK handshake toward the self-timed input pipeline. Replaces ad-hoc Send_in pulsing with a clocked, back-pressure-aware, abortable controller. Sits between the packet table (read side) and the DDP input elastic stage.

Parameters:
DEPTH, 20, number of table entries
ADDR_W, 5, table address width
PKT_W, 38, packet width
GAP_CYC, 2, idle cycles between end of one handshake and next LOAD (0 allowed)
SYNC_STAGES, 2, flip-flop stages synchronizing SEND_ACK

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  one-cycle pulse; begins a run when IDLE, ignored otherwise
STOP  input  1  one-cycle pulse; abort request, honoured at next safe point
PKT_NUM  input  ADDR_W  packets to send this run; sampled on accepted START
RD_ADDR  output  ADDR_W  table read address
RD_DATA  input  PKT_W  table read data, combinational from RD_ADDR
PACKET_OUT  output  PKT_W  registered packet presented downstream
SEND_REQ  output  1  four-phase request
SEND_ACK  input  1  four-phase acknowledge, asynchronous to CLK
PC_OUT  output  ADDR_W  index of packet currently on PACKET_OUT
SENT_CNT  output  ADDR_W+1  completed handshakes this run
BUSY  output  1  high in any state except IDLE
DONE  output  1  one-cycle pulse at run end (normal, early or aborted)

Behaviour:
- Reset (async, RST_N=0): state IDLE; RD_ADDR, PACKET_OUT, PC_OUT, SENT_CNT = 0; SEND_REQ, BUSY, DONE = 0; sync chain cleared. SEND_REQ drops immediately even mid-handshake.
- Packet fields: [37:35] header, [34:27] gen, [26:20] dest, [19:16] flags, [15:0] data. An entry is valid only when header == 3'b111.
- Run limit: LIMIT = min(PKT_NUM, DEPTH), latched on START. PKT_NUM=0 -> DONE pulse next cycle, no handshake.
- ACK_S = SEND_ACK after SYNC_STAGES flops. All ACK decisions use ACK_S only.
- States:
  IDLE: START & LIMIT>0 -> LOAD, RD_ADDR=0, SENT_CNT=0.
  LOAD (1 cycle): PACKET_OUT<=RD_DATA, PC_OUT<=RD_ADDR. Header invalid -> FIN (early end, no request). Else -> REQ_HI.
  REQ_HI: SEND_REQ=1; PACKET_OUT held stable. ACK_S=1 -> REQ_LO.
  REQ_LO: SEND_REQ=0; wait ACK_S=0; then SENT_CNT+1; if SENT_CNT+1==LIMIT or stop_pend -> FIN; else RD_ADDR+1 -> GAP (or LOAD if GAP_CYC=0).
  GAP: count GAP_CYC cycles -> LOAD.
  FIN: DONE=1 for one cycle -> IDLE.
- Latency: START to SEND_REQ rise = 2 cycles (IDLE->LOAD->REQ_HI). ACK rise to REQ fall = SYNC_STAGES+1 cycles.
- STOP: sets stop_pend. In IDLE it is ignored. In LOAD/GAP -> FIN next cycle. In REQ_HI/REQ_LO the current handshake completes fully (REQ never withdrawn before ACK), then FIN. stop_pend is cleared in FIN.
- Simultaneous START and STOP in IDLE: START wins, and STOP is discarded.
- RD_ADDR never exceeds DEPTH-1. No wrap-around within a run. Each START restarts at address 0.
- SEND_ACK already high at START: REQ_HI still asserts. The handshake completes when ACK_S is 1, so a stuck-high ACK is not detected. This is a documented limitation.

Decomposition:
- Shared package ddp_pkt_pkg: PKT_W, header/gen/dest/flags/data field offsets, HDR_VALID=3'b111, DEPTH.
- Sub-module ack_sync (SYNC_STAGES-deep, reset-clear synchronizer). The FSM stays in packet_send_ctrl.

Test Plan:
- PKT_NUM=4, ACK responder with 3-cycle delay -> 4 handshakes carrying PACKET_OUT data 0,1,2,3 in order; SENT_CNT=4; exactly one DONE pulse; BUSY low afterwards.
- PKT_NUM=8, table entry 5 all-zero -> packets 0..4 sent; LOAD at addr 5 -> FIN; SENT_CNT=5; SEND_REQ never rises for entry 5.
- STOP pulsed while REQ_HI for packet 2 with ACK held low 10 cycles -> SEND_REQ stays high until ACK; handshake completes; SENT_CNT=3; DONE; no packet 3.
- PKT_NUM=0 and PKT_NUM=25 -> first: DONE after 1 cycle, SENT_CNT=0; second: 20 packets sent, RD_ADDR maximum 19.
- RST_N low while REQ_HI -> SEND_REQ=0, BUSY=0, counters=0 without a clock edge; after release, START re-runs from address 0.
- GAP_CYC=0 build, ACK immediate -> REQ_LO goes directly to LOAD; PACKET_OUT never changes while SEND_REQ=1.
